// File: rtl/cnn_conv_pkg.sv
// Shared FP16 types and helpers for the conv datapath.
// Holds the FP16 adder used by the reduction tree and the accumulator.
package cnn_conv_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO     = 16'h0000;
  localparam fp16_t FP16_ONE      = 16'h3c00;
  localparam fp16_t FP16_SIGN_BIT = 16'h8000;
  localparam fp16_t FP16_QNAN     = 16'h7e00;

  function automatic fp16_t relu_fp16(input fp16_t v);
    return ((v & FP16_SIGN_BIT) != 16'd0) ? FP16_ZERO : v;
  endfunction

  // Round-to-nearest-even add with subnormals, inf and NaN.
  function automatic fp16_t add_fp16(input fp16_t a,
                                     input fp16_t b);
    fp16_t       x;
    fp16_t       y;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic [4:0]  d;
    logic [5:0]  e;
    logic [10:0] mx;
    logic [10:0] my;
    logic [31:0] sh;
    logic [13:0] ax;
    logic [13:0] bx;
    logic [13:0] n;
    logic [14:0] s;
    logic [3:0]  lz;
    logic [3:0]  sa;
    logic [11:0] mr;
    logic        sub;
    logic        up;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // x has the larger magnitude, so any special lives in x
    if (&x[14:10]) begin
      if (|x[9:0])
        return FP16_QNAN;
      if ((&y[14:10]) && (x[15] != y[15]))
        return FP16_QNAN;
      return x;
    end
    ex = x[14:10];
    ey = y[14:10];
    mx = {ex != 5'd0, x[9:0]};
    my = {ey != 5'd0, y[9:0]};
    if (ex == 5'd0) ex = 5'd1;
    if (ey == 5'd0) ey = 5'd1;
    d  = ex - ey;
    sh = {my, 21'd0} >> d;
    ax = {mx, 3'd0};
    bx = {sh[31:19], sh[18] | (|sh[17:0])};
    sub = x[15] ^ y[15];
    if (sub)
      s = {1'b0, ax} - {1'b0, bx};
    else
      s = {1'b0, ax} + {1'b0, bx};
    if (s == 15'd0)
      return sub ? FP16_ZERO : {x[15], 15'd0};
    e = {1'b0, ex};
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      n  = s[13:0];
      lz = 4'd14;
      for (int i = 0; i < 14; i++)
        if (n[i]) lz = 4'(13 - i);
      if ({2'd0, lz} < (e - 6'd1))
        sa = lz;
      else
        sa = 4'(e - 6'd1);
      n = n << sa;
      e = e - {2'd0, sa};
    end
    up = n[2] & (n[3] | n[1] | n[0]);
    mr = {1'b0, n[13:3]} + {11'd0, up};
    if (mr[11]) begin
      mr = 12'h400;
      e  = e + 6'd1;
    end
    if (e >= 6'd31)
      return {x[15], 5'h1f, 10'd0};
    return {x[15], mr[10] ? e[4:0] : 5'd0, mr[9:0]};
  endfunction

endpackage

// File: rtl/fp16_adder_tree_pipe.sv
// One lane's pipelined FP16 reduction tree.
// Heap layout: node i sums nodes 2i/2i+1, leaves are the inputs.
module fp16_adder_tree_pipe
  import cnn_conv_pkg::*;
#(
  parameter  int NUM_INPUTS = 8,
  localparam int L = $clog2(NUM_INPUTS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  fp16_t        in_data [NUM_INPUTS],
  output fp16_t        sum_out,
  output logic [L-1:0] stage_vld
);

  fp16_t      val    [2*NUM_INPUTS];
  fp16_t      node_d [1:NUM_INPUTS-1];
  fp16_t      node_q [1:NUM_INPUTS-1];
  logic [L-1:0] vld_d;
  logic [L-1:0] vld_q;

  // gather registered nodes and raw inputs into one heap
  always_comb begin
    for (int i = 0; i < 2*NUM_INPUTS; i++)
      val[i] = FP16_ZERO;
    for (int i = 1; i < NUM_INPUTS; i++)
      val[i] = node_q[i];
    for (int i = 0; i < NUM_INPUTS; i++)
      val[NUM_INPUTS+i] = in_data[i];
  end

  // one adder per internal node, valid shifts alongside
  always_comb begin
    for (int i = 1; i < NUM_INPUTS; i++)
      node_d[i] = add_fp16(val[2*i], val[2*i+1]);
    vld_d = L'({vld_q, valid_in});
  end

  // level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 1; i < NUM_INPUTS; i++)
        node_q[i] <= FP16_ZERO;
    end else begin
      vld_q <= vld_d;
      for (int i = 1; i < NUM_INPUTS; i++)
        node_q[i] <= node_d[i];
    end
  end

  assign sum_out   = node_q[1];
  assign stage_vld = vld_q;

endmodule

// File: rtl/conv_channel_accum.sv
// Multi-pass channel reducer: adder trees, beat accumulator,
// bias add and optional ReLU on one registered output column.
module conv_channel_accum
  import cnn_conv_pkg::*;
#(
  parameter int          DATA_WIDTH   = 16,
  parameter int          NUM_INPUTS   = 8,
  parameter int          LANES        = 2,
  parameter int          PASS_W       = 3,
  parameter logic [15:0] BIAS_DEFAULT = 16'h34f1,
  parameter int          RELU_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] partial_in [NUM_INPUTS][LANES],
  input  logic [PASS_W-1:0]     cfg_passes,
  input  logic                  bias_load,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] output_column [LANES],
  output logic                  valid_out,
  output logic                  busy
);

  localparam int L = $clog2(NUM_INPUTS);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $fatal(1, "DATA_WIDTH must be 16");
  end
  if ((NUM_INPUTS < 2) ||
      ((NUM_INPUTS & (NUM_INPUTS - 1)) != 0)) begin : g_bad_n
    $fatal(1, "NUM_INPUTS must be a power of two >= 2");
  end

  fp16_t             lane_in  [LANES][NUM_INPUTS];
  fp16_t             tree_sum [LANES];
  logic [L-1:0]      stg_vld  [LANES];
  logic              tree_busy;
  logic              t_vld;

  logic [PASS_W-1:0] pp_d [L];
  logic [PASS_W-1:0] pp_q [L];
  logic [PASS_W-1:0] cnt_d;
  logic [PASS_W-1:0] cnt_q;
  logic [PASS_W-1:0] passes_d;
  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] eff;
  fp16_t             acc_d  [LANES];
  fp16_t             acc_q  [LANES];
  fp16_t             out_d  [LANES];
  fp16_t             out_q  [LANES];
  fp16_t             sum_l  [LANES];
  fp16_t             fin_l  [LANES];
  fp16_t             bias_d;
  fp16_t             bias_q;
  logic              vout_d;
  logic              vout_q;
  logic              first;

  // transpose [input][lane] into per-lane vectors
  always_comb begin
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < NUM_INPUTS; i++)
        lane_in[l][i] = partial_in[i][l];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp16_adder_tree_pipe #(
      .NUM_INPUTS (NUM_INPUTS)
    ) u_tree (
      .clk       (clk),
      .rst_n     (rst),
      .valid_in  (valid_in),
      .in_data   (lane_in[g]),
      .sum_out   (tree_sum[g]),
      .stage_vld (stg_vld[g])
    );
  end

  // any stage valid in any lane, lane 0 drives the accumulator
  always_comb begin
    tree_busy = 1'b0;
    for (int l = 0; l < LANES; l++)
      tree_busy = tree_busy | (|stg_vld[l]);
    t_vld = stg_vld[0][L-1];
  end

  // cfg_passes travels with its beat through the tree
  always_comb begin
    pp_d[0] = cfg_passes;
    for (int k = 1; k < L; k++)
      pp_d[k] = pp_q[k-1];
  end

  // accumulate beats, final beat adds bias and applies ReLU
  always_comb begin
    cnt_d    = cnt_q;
    passes_d = passes_q;
    acc_d    = acc_q;
    out_d    = out_q;
    vout_d   = 1'b0;
    bias_d   = bias_load ? bias_in : bias_q;
    first    = (cnt_q == '0);
    eff      = passes_q;
    if (first)
      eff = (pp_q[L-1] == '0) ? PASS_W'(1) : pp_q[L-1];
    for (int l = 0; l < LANES; l++) begin
      sum_l[l] = first ? tree_sum[l]
                       : add_fp16(acc_q[l], tree_sum[l]);
      fin_l[l] = add_fp16(sum_l[l], bias_q);
      if (RELU_EN != 0)
        fin_l[l] = relu_fp16(fin_l[l]);
    end
    if (t_vld) begin
      if (first)
        passes_d = eff;
      if (cnt_q == (eff - PASS_W'(1))) begin
        out_d  = fin_l;
        vout_d = 1'b1;
        cnt_d  = '0;
      end else begin
        acc_d = sum_l;
        cnt_d = cnt_q + PASS_W'(1);
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < L; k++)
        pp_q[k] <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= FP16_ZERO;
        out_q[l] <= FP16_ZERO;
      end
      cnt_q    <= '0;
      passes_q <= '0;
      bias_q   <= BIAS_DEFAULT;
      vout_q   <= 1'b0;
    end else begin
      pp_q     <= pp_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      passes_q <= passes_d;
      bias_q   <= bias_d;
      vout_q   <= vout_d;
    end
  end

  assign output_column = out_q;
  assign valid_out     = vout_q;
  assign busy          = tree_busy | (cnt_q != '0);

endmodule

// File: tb/tb_conv_channel_accum.sv
// Bench for conv_channel_accum: directed scenarios plus
// randomized groups checked against a real-valued sum model.
module tb_conv_channel_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        bias_load = 1'b0;
  logic [2:0]  cfg_passes = 3'd0;
  logic [15:0] bias_in = 16'd0;
  logic [15:0] partial_in [8][2];
  logic [15:0] col    [2];
  logic [15:0] col_nr [2];
  logic        vout, vout_nr, busy, busy_nr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] q0[$], q1[$], n0[$], n1[$];
  int          qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_channel_accum #(
    .DATA_WIDTH(16), .NUM_INPUTS(8), .LANES(2),
    .PASS_W(3), .BIAS_DEFAULT(16'h34f1), .RELU_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .partial_in(partial_in), .cfg_passes(cfg_passes),
    .bias_load(bias_load), .bias_in(bias_in),
    .output_column(col), .valid_out(vout), .busy(busy)
  );

  conv_channel_accum #(
    .DATA_WIDTH(16), .NUM_INPUTS(8), .LANES(2),
    .PASS_W(3), .BIAS_DEFAULT(16'h34f1), .RELU_EN(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .partial_in(partial_in), .cfg_passes(cfg_passes),
    .bias_load(bias_load), .bias_in(bias_in),
    .output_column(col_nr), .valid_out(vout_nr),
    .busy(busy_nr)
  );

  always @(negedge clk) begin
    if (vout) begin
      q0.push_back(col[0]);
      q1.push_back(col[1]);
      qc.push_back(cyc);
    end
    if (vout_nr) begin
      n0.push_back(col_nr[0]);
      n1.push_back(col_nr[1]);
    end
  end

  // real -> FP16, round to nearest even
  function automatic logic [15:0] r2h(input real v);
    real a, m, fl, r;
    int  e, mi;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a >= 65520.0) return {s, 5'h1f, 10'h0};
    if (a < 2.0 ** -14) begin
      m = a * (2.0 ** 24);
      e = 0;
    end else begin
      e = -14;
      while (a >= 2.0 ** (e + 1)) e++;
      m = a * (2.0 ** (10 - e));
    end
    fl = $floor(m);
    mi = int'(fl);
    r  = m - fl;
    if (r > 0.5 || (r == 0.5 && (mi % 2) == 1)) mi++;
    if (a < 2.0 ** -14)
      return {s, (mi >= 1024) ? 5'd1 : 5'd0, 10'(mi)};
    if (mi == 2048) begin
      mi = 1024;
      e++;
    end
    if (e > 15) return {s, 5'h1f, 10'h0};
    return {s, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++)
      for (int l = 0; l < 2; l++)
        partial_in[i][l] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] v, input int p);
    set_all(v);
    cfg_passes = 3'(p);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic load_bias(input logic [15:0] v);
    bias_in = v;
    bias_load = 1'b1;
    @(negedge clk);
    bias_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); qc.delete();
    n0.delete(); n1.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (col[0] !== 16'h0 || col[1] !== 16'h0) begin
      errors++;
      $display("FAIL reset_col: got %h %h want 0000", col[0], col[1]);
    end
    checks++;
    if (vout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: vout %b busy %b want 0 0", vout, busy);
    end
  endtask

  task automatic test_single();
    int lc;
    clear_q();
    load_bias(16'h0000);
    lc = cyc;
    beat(16'h3c00, 1);
    idle(6);
    checks++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL single_cnt: got %0d want 1", q0.size());
    end else begin
      checks++;
      if (q0[0] !== 16'h4800 || q1[0] !== 16'h4800) begin
        errors++;
        $display("FAIL single_val: got %h %h want 4800", q0[0], q1[0]);
      end
      checks++;
      if (qc[0] != lc + 4) begin
        errors++;
        $display("FAIL single_lat: got %0d want 4", qc[0] - lc);
      end
    end
  endtask

  task automatic test_two_pass();
    clear_q();
    beat(16'h3c00, 2);
    idle(3);
    checks++;
    if (busy !== 1'b1 || q0.size() != 0) begin
      errors++;
      $display("FAIL two_mid: busy %b pulses %0d want 1 0", busy, q0.size());
    end
    beat(16'h3c00, 5);
    idle(6);
    checks++;
    if (q0.size() != 1) begin
      errors++;
      $display("FAIL two_cnt: got %0d want 1", q0.size());
    end else begin
      checks++;
      if (q0[0] !== 16'h4c00 || q1[0] !== 16'h4c00) begin
        errors++;
        $display("FAIL two_val: got %h %h want 4c00", q0[0], q1[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL two_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_relu();
    clear_q();
    beat(16'hbc00, 1);
    idle(6);
    checks++;
    if (q0.size() != 1 || n0.size() != 1) begin
      errors++;
      $display("FAIL relu_cnt: got %0d %0d want 1 1", q0.size(), n0.size());
    end else begin
      checks++;
      if (q0[0] !== 16'h0000 || q1[0] !== 16'h0000) begin
        errors++;
        $display("FAIL relu_on: got %h %h want 0000", q0[0], q1[0]);
      end
      checks++;
      if (n0[0] !== 16'hc800 || n1[0] !== 16'hc800) begin
        errors++;
        $display("FAIL relu_off: got %h %h want c800", n0[0], n1[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    logic [15:0] w;
    clear_q();
    lc = cyc;
    for (int i = 0; i < 6; i++)
      beat((i % 2) ? 16'h3800 : 16'h3c00, 1);
    idle(6);
    checks++;
    if (q0.size() != 6) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d want 6", q0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        w = (i % 2) ? 16'h4400 : 16'h4800;
        checks++;
        if (q0[i] !== w || q1[i] !== w || qc[i] != lc + 4 + i) begin
          errors++;
          $display("FAIL b2b_%0d: got %h %h @%0d want %h @%0d",
                   i, q0[i], q1[i], qc[i] - lc, w, 4 + i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    beat(16'h3c00, 2);
    idle(1);
    rst = 1'b0;
    #1;
    checks++;
    if (col[0] !== 16'h0 || col[1] !== 16'h0 ||
        busy !== 1'b0 || vout !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: got %h %h busy %b vout %b want 0",
               col[0], col[1], busy, vout);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(6);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL rstmid_pulse: got %0d want 0", q0.size());
    end
    load_bias(16'h0000);
    beat(16'h3c00, 2);
    beat(16'h3c00, 2);
    idle(6);
    checks++;
    if (q0.size() != 1 || q0[0] !== 16'h4c00 || q1[0] !== 16'h4c00) begin
      errors++;
      $display("FAIL rstmid_next: got %0d pulses %h want 1 4c00",
               q0.size(), (q0.size() > 0) ? q0[0] : 16'hxxxx);
    end
  endtask

  task automatic test_bias_timing();
    do_reset();
    clear_q();
    beat(16'h0000, 1);
    idle(1);
    load_bias(16'h3c00);
    idle(6);
    checks++;
    if (q0.size() != 1 || q0[0] !== 16'h3c00 || q1[0] !== 16'h3c00) begin
      errors++;
      $display("FAIL bias_early: got %0d pulses %h want 1 3c00",
               q0.size(), (q0.size() > 0) ? q0[0] : 16'hxxxx);
    end
    do_reset();
    clear_q();
    beat(16'h0000, 1);
    idle(2);
    load_bias(16'h3c00);
    idle(6);
    checks++;
    if (q0.size() != 1 || q0[0] !== 16'h34f1 || q1[0] !== 16'h34f1) begin
      errors++;
      $display("FAIL bias_same_edge: got %0d pulses %h want 1 34f1",
               q0.size(), (q0.size() > 0) ? q0[0] : 16'hxxxx);
    end
    clear_q();
    beat(16'h0000, 1);
    idle(6);
    checks++;
    if (q0.size() != 1 || q0[0] !== 16'h3c00) begin
      errors++;
      $display("FAIL bias_after: got %0d pulses %h want 1 3c00",
               q0.size(), (q0.size() > 0) ? q0[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    logic [15:0] e0[$], e1[$], x0[$], x1[$];
    real tot [2];
    real bias_r, v;
    logic [15:0] f;
    int p, np, k, nmin;
    do_reset();
    clear_q();
    bias_r = real'(int'($urandom_range(32)) - 16) * 0.25;
    load_bias(r2h(bias_r));
    for (int g = 0; g < 30; g++) begin
      if (g == 15) begin
        idle(6);
        bias_r = real'(int'($urandom_range(32)) - 16) * 0.25;
        load_bias(r2h(bias_r));
      end
      p  = int'($urandom_range(7));
      np = (p == 0) ? 1 : p;
      tot[0] = 0.0;
      tot[1] = 0.0;
      for (int b = 0; b < np; b++) begin
        idle(int'($urandom_range(2)));
        for (int i = 0; i < 8; i++)
          for (int l = 0; l < 2; l++) begin
            k = int'($urandom_range(32)) - 16;
            v = real'(k) * 0.25;
            partial_in[i][l] = r2h(v);
            tot[l] += v;
          end
        cfg_passes = (b == 0) ? 3'(p) : 3'($urandom_range(7));
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
      end
      f = r2h(tot[0] + bias_r);
      x0.push_back(f);
      e0.push_back(f[15] ? 16'h0000 : f);
      f = r2h(tot[1] + bias_r);
      x1.push_back(f);
      e1.push_back(f[15] ? 16'h0000 : f);
    end
    idle(8);
    checks++;
    if (q0.size() != e0.size() || n0.size() != e0.size()) begin
      errors++;
      $display("FAIL rand_cnt: got %0d %0d want %0d",
               q0.size(), n0.size(), e0.size());
    end
    nmin = e0.size();
    if (q0.size() < nmin) nmin = q0.size();
    if (n0.size() < nmin) nmin = n0.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (q0[i] !== e0[i] || q1[i] !== e1[i] ||
          n0[i] !== x0[i] || n1[i] !== x1[i]) begin
        errors++;
        $display("FAIL rand_%0d: got %h %h / %h %h want %h %h / %h %h",
                 i, q0[i], q1[i], n0[i], n1[i],
                 e0[i], e1[i], x0[i], x1[i]);
      end
    end
  endtask

  initial begin
    set_all(16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    test_single();
    test_two_pass();
    test_relu();
    test_back_to_back();
    test_reset_mid();
    test_bias_timing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
